// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between the fetch port and the data port.
// Data has priority; a starvation counter forces a fetch grant after STARVE_MAX data wins.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [ADDR_W-1:0] if_req_addr,
    input  logic              if_flush,
    output logic              if_resp_valid,
    output logic [DATA_W-1:0] if_resp_data,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_req_we,
    input  logic [3:0]        d_req_sel,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [DATA_W-1:0] d_req_wdata,
    output logic              d_resp_valid,
    output logic [DATA_W-1:0] d_resp_data,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [3:0]        mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        o_dbg_state,
    output logic [3:0]        o_dbg_starve_cnt
);

    // Handshake: a request transfers on a rising clk edge where valid and ready are both
    // high; the requester holds valid and payload stable until then.

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF   = 2'd1;
    localparam logic [1:0] OWN_D    = 2'd2;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [1:0]        r_state;
    logic [1:0]        r_owner;
    logic [3:0]        r_starve_cnt;
    logic              r_drop;
    logic              r_we;
    logic [3:0]        r_sel;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic w_idle;
    logic w_if_want;
    logic w_grant_if;
    logic w_grant_d;
    logic w_resp;
    logic w_resp_if;
    logic w_resp_d;

    assign w_idle     = (r_state == IDLE);
    assign w_if_want  = if_req_valid & ~if_flush;
    // Readies are gated by rst_n so no handshake can be seen while reset is pending.
    assign w_grant_if = rst_n & w_idle & w_if_want &
                        (~d_req_valid | (r_starve_cnt == STARVE_LIM));
    assign w_grant_d  = rst_n & w_idle & d_req_valid & ~w_grant_if;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_owner      <= OWN_NONE;
            r_starve_cnt <= 4'd0;
            r_drop       <= 1'b0;
            r_we         <= 1'b0;
            r_sel        <= 4'd0;
            r_addr       <= '0;
            r_wdata      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_drop <= 1'b0;
                    if (w_grant_if) begin
                        r_state      <= ACCESS;
                        r_owner      <= OWN_IF;
                        r_we         <= 1'b0;
                        r_sel        <= 4'hF;
                        r_addr       <= if_req_addr;
                        r_wdata      <= '0;
                        r_starve_cnt <= 4'd0;
                    end else if (w_grant_d) begin
                        r_state <= ACCESS;
                        r_owner <= OWN_D;
                        r_we    <= d_req_we;
                        r_sel   <= d_req_sel;
                        r_addr  <= d_req_addr;
                        r_wdata <= d_req_wdata;
                        if (!w_if_want) begin
                            r_starve_cnt <= 4'd0;
                        end else if (r_starve_cnt >= STARVE_LIM) begin
                            r_starve_cnt <= STARVE_LIM;
                        end else begin
                            r_starve_cnt <= r_starve_cnt + 4'd1;
                        end
                    end
                end
                ACCESS: begin
                    r_state <= RESP;
                    if (if_flush && (r_owner == OWN_IF)) begin
                        r_drop <= 1'b1;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                    r_owner <= OWN_NONE;
                    r_drop  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_owner <= OWN_NONE;
                end
            endcase
        end
    end

    assign if_req_ready = w_grant_if;
    assign d_req_ready  = w_grant_d;

    assign mem_ce    = (r_state == ACCESS);
    assign mem_we    = mem_ce & r_we;
    assign mem_sel   = r_sel;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    // A flush arriving in the response cycle itself also hides the fetch response.
    assign w_resp        = (r_state == RESP);
    assign w_resp_if     = w_resp & (r_owner == OWN_IF);
    assign w_resp_d      = w_resp & (r_owner == OWN_D);
    assign if_resp_valid = w_resp_if & ~r_drop & ~if_flush;
    assign if_resp_data  = w_resp_if ? mem_rdata : '0;
    assign d_resp_valid  = w_resp_d;
    assign d_resp_data   = (w_resp_d & ~r_we) ? mem_rdata : '0;

    assign o_dbg_state      = r_state;
    assign o_dbg_starve_cnt = r_starve_cnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: timeline reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              if_req_valid = 1'b0;
    logic              if_req_ready;
    logic [ADDR_W-1:0] if_req_addr = '0;
    logic              if_flush = 1'b0;
    logic              if_resp_valid;
    logic [DATA_W-1:0] if_resp_data;
    logic              d_req_valid = 1'b0;
    logic              d_req_ready;
    logic              d_req_we = 1'b0;
    logic [3:0]        d_req_sel = 4'd0;
    logic [ADDR_W-1:0] d_req_addr = '0;
    logic [DATA_W-1:0] d_req_wdata = '0;
    logic              d_resp_valid;
    logic [DATA_W-1:0] d_resp_data;
    logic              mem_ce;
    logic              mem_we;
    logic [3:0]        mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic [1:0]        o_dbg_state;
    logic [3:0]        o_dbg_starve_cnt;

    mem_port_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .if_req_valid    (if_req_valid),
        .if_req_ready    (if_req_ready),
        .if_req_addr     (if_req_addr),
        .if_flush        (if_flush),
        .if_resp_valid   (if_resp_valid),
        .if_resp_data    (if_resp_data),
        .d_req_valid     (d_req_valid),
        .d_req_ready     (d_req_ready),
        .d_req_we        (d_req_we),
        .d_req_sel       (d_req_sel),
        .d_req_addr      (d_req_addr),
        .d_req_wdata     (d_req_wdata),
        .d_resp_valid    (d_resp_valid),
        .d_resp_data     (d_resp_data),
        .mem_ce          (mem_ce),
        .mem_we          (mem_we),
        .mem_sel         (mem_sel),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .o_dbg_state     (o_dbg_state),
        .o_dbg_starve_cnt(o_dbg_starve_cnt)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // A grant decided in cycle g means: memory strobe in g+1, response in g+2, idle again in g+3.
    int          cyc = 0;
    int          g_cyc = 0;
    int          k = 0;
    bit          busy = 1'b0;
    bit          m_own_d = 1'b0;
    bit          m_drop = 1'b0;
    bit          m_sel_known = 1'b1;
    logic        m_we = 1'b0;
    logic [3:0]  m_sel = 4'd0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    int          m_starve = 0;
    logic        e_if_rdy, e_d_rdy, e_ce, e_we, e_ifv, e_dv, fetch_ok;
    logic [31:0] e_ifd, e_dd;

    always @(negedge clk) begin
        cyc++;
        k = busy ? (cyc - g_cyc) : 0;
        if (busy && k >= 3) begin
            busy = 1'b0;
            k = 0;
        end
        e_if_rdy = 1'b0; e_d_rdy = 1'b0; e_ce = 1'b0; e_we = 1'b0;
        e_ifv = 1'b0; e_dv = 1'b0; e_ifd = '0; e_dd = '0;
        if (k == 0) begin
            if (rst_n) begin
                fetch_ok = if_req_valid && !if_flush && (!d_req_valid || m_starve == STARVE_MAX);
                e_if_rdy = fetch_ok;
                e_d_rdy  = d_req_valid && !fetch_ok;
            end
        end else if (k == 1) begin
            e_ce = 1'b1;
            e_we = m_we;
            if (if_flush && !m_own_d) m_drop = 1'b1;
        end else begin
            if (!m_own_d) begin
                e_ifv = !m_drop && !if_flush;
                e_ifd = mem_rdata;
            end else begin
                e_dv = 1'b1;
                e_dd = m_we ? 32'd0 : mem_rdata;
            end
        end

        check("if_req_ready", 64'(if_req_ready), 64'(e_if_rdy));
        check("d_req_ready", 64'(d_req_ready), 64'(e_d_rdy));
        check("mem_ce", 64'(mem_ce), 64'(e_ce));
        check("mem_we", 64'(mem_we), 64'(e_we));
        check("mem_addr", 64'(mem_addr), 64'(m_addr));
        if (m_sel_known) begin
            check("mem_sel", 64'(mem_sel), 64'(m_sel));
            check("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
        end
        check("if_resp_valid", 64'(if_resp_valid), 64'(e_ifv));
        check("d_resp_valid", 64'(d_resp_valid), 64'(e_dv));
        if (k != 2 || e_ifv) check("if_resp_data", 64'(if_resp_data), 64'(e_ifd));
        if (k != 2 || e_dv) check("d_resp_data", 64'(d_resp_data), 64'(e_dd));
        check("starve_cnt", 64'(o_dbg_starve_cnt), 64'(m_starve));

        if (!rst_n) begin
            busy = 1'b0; m_starve = 0; m_we = 1'b0; m_sel = 4'd0;
            m_addr = '0; m_wdata = '0; m_sel_known = 1'b1; m_drop = 1'b0;
        end else if (e_if_rdy) begin
            busy = 1'b1; g_cyc = cyc; m_own_d = 1'b0; m_drop = 1'b0;
            m_we = 1'b0; m_addr = if_req_addr; m_sel_known = 1'b0; m_starve = 0;
        end else if (e_d_rdy) begin
            busy = 1'b1; g_cyc = cyc; m_own_d = 1'b1; m_drop = 1'b0;
            m_we = d_req_we; m_sel = d_req_sel; m_addr = d_req_addr;
            m_wdata = d_req_wdata; m_sel_known = 1'b1;
            if (if_req_valid && !if_flush)
                m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
            else
                m_starve = 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;
        if_flush     = 1'b0;
    endtask

    logic [9:0] seq;
    int         ngr;
    int         last_g;
    bit         spacing_ok;
    bit         hs_if, hs_d;

    initial begin
        // reset; readies must stay low even with a request pending
        rst_n = 1'b0;
        if_req_valid = 1'b1;
        tick();
        mid();
        check("reset if_req_ready", 64'(if_req_ready), 64'd0);
        check("reset mem_ce", 64'(mem_ce), 64'd0);
        check("reset state", 64'(o_dbg_state), 64'd0);
        tick();
        idle_inputs();
        tick();
        rst_n = 1'b1;
        tick();

        // fetch only
        if_req_valid = 1'b1; if_req_addr = 32'h1c00_0000; mem_rdata = 32'h02c0_0000;
        mid(); check("fetch c0 ready", 64'(if_req_ready), 64'd1);
        tick(); if_req_valid = 1'b0;
        mid(); check("fetch c1 ce", 64'(mem_ce), 64'd1);
        check("fetch c1 addr", 64'(mem_addr), 64'h1c00_0000);
        check("fetch c1 we", 64'(mem_we), 64'd0);
        tick();
        mid(); check("fetch c2 valid", 64'(if_resp_valid), 64'd1);
        check("fetch c2 data", 64'(if_resp_data), 64'h02c0_0000);
        tick();

        // data write
        d_req_valid = 1'b1; d_req_we = 1'b1; d_req_sel = 4'b0011;
        d_req_addr = 32'h100; d_req_wdata = 32'h1234_5678; mem_rdata = 32'hffff_ffff;
        mid(); check("write c0 ready", 64'(d_req_ready), 64'd1);
        tick(); d_req_valid = 1'b0;
        mid(); check("write c1 ce", 64'(mem_ce), 64'd1);
        check("write c1 we", 64'(mem_we), 64'd1);
        check("write c1 sel", 64'(mem_sel), 64'b0011);
        check("write c1 wdata", 64'(mem_wdata), 64'h1234_5678);
        tick();
        mid(); check("write c2 valid", 64'(d_resp_valid), 64'd1);
        check("write c2 data", 64'(d_resp_data), 64'd0);
        tick();

        // starvation guard: both requesters held continuously
        if_req_valid = 1'b1; if_req_addr = 32'h1c00_0100;
        d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h180; d_req_sel = 4'hF;
        seq = '0; ngr = 0; last_g = -3; spacing_ok = 1'b1;
        for (int i = 0; i < 30; i++) begin
            mid();
            if (if_req_ready || d_req_ready) begin
                seq = {seq[8:0], if_req_ready};
                if (ngr > 0 && i - last_g != 3) spacing_ok = 1'b0;
                last_g = i;
                ngr++;
            end
            tick();
        end
        idle_inputs();
        check("starve grant count", 64'(ngr), 64'd10);
        check("starve grant order", 64'(seq), 64'b0000100001);
        check("starve grant spacing", 64'(spacing_ok), 64'd1);

        // flush of an in-flight fetch
        if_req_valid = 1'b1; if_req_addr = 32'h1c00_0040; mem_rdata = 32'h5555_aaaa;
        mid(); check("flush c0 ready", 64'(if_req_ready), 64'd1);
        tick(); if_req_valid = 1'b0; if_flush = 1'b1;
        mid(); check("flush c1 ce", 64'(mem_ce), 64'd1);
        tick(); if_flush = 1'b0;
        mid(); check("flush c2 dropped", 64'(if_resp_valid), 64'd0);
        tick(); if_req_valid = 1'b1; if_req_addr = 32'h1c00_0044; mem_rdata = 32'h0bad_cafe;
        mid(); check("flush c3 ready", 64'(if_req_ready), 64'd1);
        tick(); if_req_valid = 1'b0;
        mid(); tick();
        mid(); check("flush c5 valid", 64'(if_resp_valid), 64'd1);
        check("flush c5 data", 64'(if_resp_data), 64'h0bad_cafe);
        tick();

        // flush while idle blocks fetch, not data
        if_req_valid = 1'b1; d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h400;
        mid(); check("iflush data first", 64'(d_req_ready), 64'd1);
        tick(); d_req_valid = 1'b0;
        mid(); tick(); mid(); tick();
        if_flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mid();
            check("iflush ready", 64'(if_req_ready), 64'd0);
            check("iflush ce", 64'(mem_ce), 64'd0);
            check("iflush starve", 64'(o_dbg_starve_cnt), 64'd1);
            tick();
        end
        d_req_valid = 1'b1;
        mid(); check("iflush data grant", 64'(d_req_ready), 64'd1);
        tick(); idle_inputs();
        mid(); check("iflush starve cleared", 64'(o_dbg_starve_cnt), 64'd0);
        tick(); mid(); tick();

        // reset during a data read
        d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 32'h200; d_req_sel = 4'hF;
        mem_rdata = 32'h1111_2222;
        mid(); check("rst c0 ready", 64'(d_req_ready), 64'd1);
        tick(); d_req_valid = 1'b0; rst_n = 1'b0;
        mid(); check("rst c1 ce", 64'(mem_ce), 64'd1);
        tick();
        mid(); check("rst c2 ce", 64'(mem_ce), 64'd0);
        check("rst c2 addr", 64'(mem_addr), 64'd0);
        check("rst c2 sel", 64'(mem_sel), 64'd0);
        check("rst c2 resp", 64'(d_resp_valid), 64'd0);
        check("rst c2 state", 64'(o_dbg_state), 64'd0);
        tick(); rst_n = 1'b1;
        mid(); check("rst c3 resp", 64'(d_resp_valid), 64'd0);
        tick();
        d_req_valid = 1'b1; d_req_addr = 32'h300; mem_rdata = 32'hcafe_f00d;
        mid(); check("rst fresh ready", 64'(d_req_ready), 64'd1);
        tick(); d_req_valid = 1'b0;
        mid(); tick();
        mid(); check("rst fresh valid", 64'(d_resp_valid), 64'd1);
        check("rst fresh data", 64'(d_resp_data), 64'hcafe_f00d);
        tick();

        // randomized traffic; payload changes freely once a request is accepted
        for (int i = 0; i < 1500; i++) begin
            mid();
            hs_if = if_req_valid & if_req_ready;
            hs_d  = d_req_valid & d_req_ready;
            tick();
            if (!if_req_valid || hs_if) begin
                if_req_valid = ($urandom_range(0, 3) != 0);
                if_req_addr  = $urandom;
            end
            if (!d_req_valid || hs_d) begin
                d_req_valid = ($urandom_range(0, 3) != 0);
                d_req_we    = 1'($urandom_range(0, 1));
                d_req_sel   = 4'($urandom_range(0, 15));
                d_req_addr  = $urandom;
                d_req_wdata = $urandom;
            end
            if_flush  = ($urandom_range(0, 9) == 0);
            mem_rdata = $urandom;
        end
        idle_inputs();
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
